// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write-port arbiter between pipeline writeback and a long-latency unit
// The pipeline owns the port; a parked long-latency result drains on free slots or via a one-cycle forced stall.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        mc_valid,
  input  logic [4:0]  mc_rd,
  input  logic [31:0] mc_data,
  output logic        mc_ready,
  output logic        stall_pipe,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        pend_valid,
  output logic [4:0]  pend_rd
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, FORCE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [4:0]         hold_rd_q, hold_rd_d;
  logic [31:0]        hold_data_q, hold_data_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               pipe_slot;

  // x0 writes never use the port, so they count as a free slot for the held result.
  assign pipe_slot = rst && pipe_we && (pipe_rd != 5'd0) && (state_q != FORCE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_rd_q   <= 5'd0;
      hold_data_q <= 32'd0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      hold_rd_q   <= hold_rd_d;
      hold_data_q <= hold_data_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_rd_d   = hold_rd_q;
    hold_data_d = hold_data_q;
    wait_cnt_d  = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (mc_valid && (mc_rd != 5'd0)) begin
          state_d     = WAIT;
          hold_rd_d   = mc_rd;
          hold_data_d = mc_data;
          wait_cnt_d  = '0;
        end
      end
      WAIT: begin
        if (!pipe_slot) begin
          state_d = IDLE;
        end else if (wait_cnt_q == CNT_W'(STARVE_LIMIT - 1)) begin
          state_d = FORCE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      FORCE: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    mc_ready   = rst && (state_q == IDLE);
    stall_pipe = rst && (state_q == FORCE);
    pend_valid = rst && (state_q != IDLE);
    pend_rd    = pend_valid ? hold_rd_q : 5'd0;
    rf_we      = 1'b0;
    rf_waddr   = 5'd0;
    rf_wdata   = 32'd0;
    if (pipe_slot) begin
      rf_we    = 1'b1;
      rf_waddr = pipe_rd;
      rf_wdata = pipe_data;
    end else if (pend_valid) begin
      rf_we    = 1'b1;
      rf_waddr = hold_rd_q;
      rf_wdata = hold_data_q;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - scoreboard bench for wb_port_arbiter
module tb_wb_port_arbiter;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ready, stall_pipe, rf_we, pend_valid;
  logic [4:0]  rf_waddr, pend_rd;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  wb_port_arbiter #(.STARVE_LIMIT(LIM), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data),
    .mc_ready(mc_ready), .stall_pipe(stall_pipe),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_valid(pend_valid), .pend_rd(pend_rd)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rdy;
    logic        stall;
    logic        pv;
    logic [4:0]  prd;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  // Reference model: an optional parked result plus how many cycles it has been blocked.
  bit          m_held = 0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_data = '0;
  int          m_age = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp_v);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rf_we", {31'd0, rf_we}, {31'd0, e.we});
        chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.wa});
        chk("rf_wdata", rf_wdata, e.wd);
        chk("mc_ready", {31'd0, mc_ready}, {31'd0, e.rdy});
        chk("stall_pipe", {31'd0, stall_pipe}, {31'd0, e.stall});
        chk("pend_valid", {31'd0, pend_valid}, {31'd0, e.pv});
        chk("pend_rd", {27'd0, pend_rd}, {27'd0, e.prd});
      end
    end
  end

  task automatic step(input logic r, input logic pwe, input logic [4:0] prd, input logic [31:0] pd,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                      output logic stalled, output logic accepted);
    exp_t e;
    bit forced, pslot;
    rst = r; pipe_we = pwe; pipe_rd = prd; pipe_data = pd;
    mc_valid = mv; mc_rd = mrd; mc_data = md;
    e = '0;
    stalled = 1'b0;
    accepted = 1'b0;
    if (r) begin
      forced   = m_held && (m_age == LIM);
      pslot    = pwe && (prd != 5'd0) && !forced;
      e.rdy    = !m_held;
      e.stall  = forced;
      e.pv     = m_held;
      e.prd    = m_held ? m_rd : 5'd0;
      if (pslot) begin
        e.we = 1'b1; e.wa = prd; e.wd = pd;
      end else if (m_held) begin
        e.we = 1'b1; e.wa = m_rd; e.wd = m_data;
      end
      stalled  = forced;
      accepted = mv && !m_held;
      if (m_held) begin
        if (forced || !pslot) m_held = 0;
        else m_age++;
      end else if (mv && (mrd != 5'd0)) begin
        m_held = 1; m_rd = mrd; m_data = md; m_age = 0;
      end
    end else begin
      m_held = 0;
      m_age = 0;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic pipe_write(input logic [4:0] prd, input logic [31:0] pd);
    logic st, ac;
    int guard;
    guard = 0;
    st = 1'b1;
    while (st && guard < 4) begin
      step(1, 1, prd, pd, 0, 0, 0, st, ac);
      guard++;
    end
  endtask

  initial begin
    logic st, ac;
    logic cw, cmv, r;
    logic [4:0] crd, cmrd;
    logic [31:0] cpd, cmd;
    int guard;
    rst = 0; pipe_we = 0; pipe_rd = 0; pipe_data = 0;
    mc_valid = 0; mc_rd = 0; mc_data = 0;
    @(posedge clk); #1;

    step(0, 1, 5, 32'h1111_1111, 1, 6, 32'h2222_2222, st, ac);
    step(0, 1, 5, 32'h1111_1111, 1, 6, 32'h2222_2222, st, ac);
    step(1, 0, 0, 0, 0, 0, 0, st, ac);

    step(1, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, st, ac);

    step(1, 0, 0, 0, 1, 7, 32'h1234_5678, st, ac);
    step(1, 0, 0, 0, 0, 0, 0, st, ac);
    step(1, 0, 0, 0, 0, 0, 0, st, ac);

    step(1, 0, 0, 0, 1, 9, 32'h9999_0009, st, ac);
    for (int i = 1; i <= 5; i++) pipe_write(5'(i), 32'hA000_0000 + i);
    step(1, 0, 0, 0, 0, 0, 0, st, ac);

    step(1, 0, 0, 0, 1, 3, 32'h0000_0333, st, ac);
    step(1, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, st, ac);
    step(1, 0, 0, 0, 1, 0, 32'h0BAD_0BAD, st, ac);
    step(1, 0, 0, 0, 0, 0, 0, st, ac);

    step(1, 0, 0, 0, 1, 12, 32'hC0C0_C0C0, st, ac);
    step(1, 1, 6, 32'h6666_6666, 0, 0, 0, st, ac);
    step(1, 1, 7, 32'h7777_7777, 0, 0, 0, st, ac);
    step(0, 1, 8, 32'h8888_8888, 0, 0, 0, st, ac);
    step(1, 0, 0, 0, 0, 0, 0, st, ac);
    step(1, 0, 0, 0, 0, 0, 0, st, ac);

    st = 0; ac = 1; cmv = 0;
    cw = 0; crd = 0; cpd = 0; cmrd = 0; cmd = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!st) begin
        cw  = ($urandom_range(0, 9) < 7);
        crd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        cpd = $urandom;
      end
      if (!cmv || ac) begin
        cmv  = ($urandom_range(0, 1) == 1);
        cmrd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        cmd  = $urandom;
      end
      r = ($urandom_range(0, 99) != 0);
      step(r, cw, crd, cpd, cmv, cmrd, cmd, st, ac);
      if (!r) begin
        st = 0; ac = 1;
      end
    end

    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d queued expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
